// File: rtl/pacman_pkg.sv
// Shared definitions for the Pac-Man tile-map memory: widths, tile codes,
// and an address range helper used by both memory ports.
package pacman_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 3;

  // Tile codes stored per maze cell
  typedef enum logic [2:0] {
    TILE_EMPTY = 3'd0,
    TILE_WALL  = 3'd1,
    TILE_DOT   = 3'd2,
    TILE_POWER = 3'd3,
    TILE_PAC   = 3'd4,
    TILE_GHOST = 3'd5
  } tile_e;

  // True when an address falls inside the populated part of the map
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned       depth);
    return (32'(addr) < depth);
  endfunction

endpackage

// File: rtl/tile_mem_dp.sv
// Simple dual-port tile RAM: port A writes and reads (read-first, with read
// enable), port B is a free-running read-only port. No reset on the array or
// the read registers so the structure maps onto a block RAM.
module tile_mem_dp #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] dout_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] dout_b
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_a_q;
  logic [DATA_W-1:0] dout_b_q;

  // Array write plus both registered reads; reads see the pre-write contents
  always_ff @(posedge clk) begin
    if (we_a) begin
      mem_q[addr_a] <= din_a;
    end
    if (re_a) begin
      dout_a_q <= mem_q[addr_a];
    end
    dout_b_q <= mem_q[addr_b];
  end

  assign dout_a = dout_a_q;
  assign dout_b = dout_b_q;

endmodule

// File: rtl/pacman_tile_ram.sv
// Pac-Man tile map: game-logic read/write port, VGA read-only port, and a
// register that remembers the last cell written with the Pac-Man code.
// The RAM read registers carry no reset; small valid flops in this module
// force the visible outputs to zero after reset and for out-of-range reads.
module pacman_tile_ram #(
  parameter int                    ADDR_W    = pacman_pkg::ADDR_W,
  parameter int                    DEPTH     = 2048,
  parameter int                    DATA_W    = pacman_pkg::DATA_W,
  parameter logic [DATA_W-1:0]     PAC_CODE  = 3'd4,
  parameter logic [ADDR_W-1:0]     PAC_START = 11'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_vga,
  output logic [DATA_W-1:0] dout_vga,
  input  logic [ADDR_W-1:0] addr_game_logic,
  input  logic              wr_game_logic,
  input  logic              rd_game_logic,
  input  logic [DATA_W-1:0] din_game_logic,
  output logic [DATA_W-1:0] dout_game_logic_par,
  output logic [ADDR_W-1:0] dout_game_logic_pac
);

  import pacman_pkg::*;

  logic              gl_in_range_s;
  logic              vga_in_range_s;
  logic              wr_en_s;
  logic              pac_hit_s;
  logic [DATA_W-1:0] ram_gl_s;
  logic [DATA_W-1:0] ram_vga_s;

  logic              gl_valid_d,  gl_valid_q;
  logic              vga_valid_d, vga_valid_q;
  logic [ADDR_W-1:0] pac_d,       pac_q;

  tile_mem_dp #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk    (clk),
    .we_a   (wr_en_s),
    .re_a   (rd_game_logic),
    .addr_a (addr_game_logic),
    .din_a  (din_game_logic),
    .dout_a (ram_gl_s),
    .addr_b (addr_vga),
    .dout_b (ram_vga_s)
  );

  // Range masking, write gating (no writes while reset is held) and next state
  always_comb begin
    gl_in_range_s  = addr_in_range(addr_game_logic, 32'(DEPTH));
    vga_in_range_s = addr_in_range(addr_vga, 32'(DEPTH));

    if (wr_game_logic && gl_in_range_s && !rst) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end

    if (wr_game_logic && gl_in_range_s && (din_game_logic == PAC_CODE)) begin
      pac_hit_s = 1'b1;
    end else begin
      pac_hit_s = 1'b0;
    end

    if (pac_hit_s) begin
      pac_d = addr_game_logic;
    end else begin
      pac_d = pac_q;
    end

    // The game read output only moves when a read is strobed
    if (rd_game_logic) begin
      gl_valid_d = gl_in_range_s;
    end else begin
      gl_valid_d = gl_valid_q;
    end

    vga_valid_d = vga_in_range_s;
  end

  // Output qualifiers and the Pac-Man position, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gl_valid_q  <= 1'b0;
      vga_valid_q <= 1'b0;
      pac_q       <= PAC_START;
    end else begin
      gl_valid_q  <= gl_valid_d;
      vga_valid_q <= vga_valid_d;
      pac_q       <= pac_d;
    end
  end

  assign dout_game_logic_par = gl_valid_q  ? ram_gl_s  : {DATA_W{1'b0}};
  assign dout_vga            = vga_valid_q ? ram_vga_s : {DATA_W{1'b0}};
  assign dout_game_logic_pac = pac_q;

endmodule

// File: tb/tb_pacman_tile_ram.sv
// Scoreboard bench for pacman_tile_ram: directed vectors push hand-computed
// expectations tagged with the cycle they are due; a monitor on the falling
// edge pops and compares them against the DUT outputs.
module tb_pacman_tile_ram;

  logic        clk;
  logic        rst;
  logic [10:0] addr_vga;
  logic [2:0]  dout_vga;
  logic [10:0] addr_game_logic;
  logic        wr_game_logic;
  logic        rd_game_logic;
  logic [2:0]  din_game_logic;
  logic [2:0]  dout_game_logic_par;
  logic [10:0] dout_game_logic_pac;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  localparam int P_PAR = 0;
  localparam int P_VGA = 1;
  localparam int P_PAC = 2;

  typedef struct {
    int          due;
    int          port;
    logic [10:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  pacman_tile_ram dut (
    .clk                 (clk),
    .rst                 (rst),
    .addr_vga            (addr_vga),
    .dout_vga            (dout_vga),
    .addr_game_logic     (addr_game_logic),
    .wr_game_logic       (wr_game_logic),
    .rd_game_logic       (rd_game_logic),
    .din_game_logic      (din_game_logic),
    .dout_game_logic_par (dout_game_logic_par),
    .dout_game_logic_pac (dout_game_logic_pac)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expectation for the edge that consumes the inputs just driven
  task automatic push(input int port, input logic [10:0] exp, input string name);
    exp_t e;
    e.due  = cyc + 1;
    e.port = port;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of stimulus just after a falling edge
  task automatic drive(input logic wr, input logic rd, input logic [10:0] a,
                       input logic [2:0] d, input logic [10:0] av);
    @(negedge clk);
    wr_game_logic   = wr;
    rd_game_logic   = rd;
    addr_game_logic = a;
    din_game_logic  = d;
    addr_vga        = av;
  endtask

  // Monitor: compare every expectation whose cycle has arrived
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      case (e.port)
        P_PAR:   chk(e.name, {8'd0, dout_game_logic_par}, e.exp);
        P_VGA:   chk(e.name, {8'd0, dout_vga}, e.exp);
        default: chk(e.name, dout_game_logic_pac, e.exp);
      endcase
    end
  end

  initial begin
    rst             = 1'b1;
    addr_vga        = 11'h000;
    addr_game_logic = 11'h000;
    wr_game_logic   = 1'b0;
    rd_game_logic   = 1'b0;
    din_game_logic  = 3'd0;

    #1;
    chk("rst_par", {8'd0, dout_game_logic_par}, 11'd0);
    chk("rst_vga", {8'd0, dout_vga}, 11'd0);
    chk("rst_pac", dout_game_logic_pac, 11'h000);
    @(negedge clk);
    rst = 1'b0;

    // Basic write/read at address 0
    drive(1'b1, 1'b0, 11'h000, 3'd2, 11'h000); push(P_PAC, 11'h000, "wr0_pac");
    drive(1'b0, 1'b1, 11'h000, 3'd0, 11'h000); push(P_PAR, 11'd2, "rd0_par");
                                               push(P_PAC, 11'h000, "rd0_pac");
    // Pac-Man tracking, plus read output hold while memory changes
    drive(1'b1, 1'b0, 11'h123, 3'd4, 11'h000); push(P_PAC, 11'h123, "pac_123");
    drive(1'b1, 1'b0, 11'h123, 3'd0, 11'h000); push(P_PAC, 11'h123, "pac_keep");
                                               push(P_PAR, 11'd2, "par_hold");
    drive(1'b1, 1'b0, 11'h7FF, 3'd4, 11'h000); push(P_PAC, 11'h7FF, "pac_7ff");
    // Hold: rd=0 while the cell under addr_game_logic changes
    drive(1'b1, 1'b0, 11'h000, 3'd3, 11'h000); push(P_PAR, 11'd2, "par_hold_same");
    // VGA port
    drive(1'b1, 1'b0, 11'h040, 3'd1, 11'h040);
    drive(1'b0, 1'b0, 11'h000, 3'd0, 11'h040); push(P_VGA, 11'd1, "vga_040");
    // Read-first collision on both ports
    drive(1'b1, 1'b0, 11'h010, 3'd3, 11'h000);
    drive(1'b1, 1'b1, 11'h010, 3'd5, 11'h010); push(P_PAR, 11'd3, "coll_par_old");
                                               push(P_VGA, 11'd3, "coll_vga_old");
    drive(1'b0, 1'b1, 11'h010, 3'd0, 11'h010); push(P_PAR, 11'd5, "coll_par_new");
                                               push(P_VGA, 11'd5, "coll_vga_new");
    drive(1'b0, 1'b1, 11'h123, 3'd0, 11'h010); push(P_PAR, 11'd0, "rd_123");
    drive(1'b0, 1'b1, 11'h7FF, 3'd0, 11'h010); push(P_PAR, 11'd4, "rd_7ff");
                                               push(P_PAC, 11'h7FF, "pac_still");

    // Async reset between edges with nonzero outputs; a write is attempted
    @(negedge clk);
    @(posedge clk);
    #2;
    rst             = 1'b1;
    wr_game_logic   = 1'b1;
    rd_game_logic   = 1'b0;
    addr_game_logic = 11'h010;
    din_game_logic  = 3'd2;
    #1;
    chk("arst_par", {8'd0, dout_game_logic_par}, 11'd0);
    chk("arst_vga", {8'd0, dout_vga}, 11'd0);
    chk("arst_pac", dout_game_logic_pac, 11'h000);
    @(posedge clk);
    #1;
    chk("arst_hold_pac", dout_game_logic_pac, 11'h000);
    @(negedge clk);
    rst           = 1'b0;
    wr_game_logic = 1'b0;

    // Contents survive reset and the write under reset was discarded
    drive(1'b0, 1'b1, 11'h010, 3'd0, 11'h010); push(P_PAR, 11'd5, "post_rst_par");
                                               push(P_VGA, 11'd5, "post_rst_vga");
                                               push(P_PAC, 11'h000, "post_rst_pac");
    drive(1'b0, 1'b1, 11'h040, 3'd0, 11'h010); push(P_PAR, 11'd1, "post_rst_040");
    drive(1'b0, 1'b1, 11'h000, 3'd0, 11'h010); push(P_PAR, 11'd3, "post_rst_000");
    drive(1'b0, 1'b0, 11'h000, 3'd0, 11'h010);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
